bus_transfer_arbiter: RTL and testbench

Shares the 32-bit internal bus between NUM_REQ requesters (control unit, I/O port, debug loader, etc.). The block arbitrates round-robin and latches the winner's source code. It then drives the bus multiplexer select and pulses a one-hot destination load enable, completing one register-to-register transfer per grant. It sits beside the bus multiplexer and owns its 5-bit select input.

---
 rtl/bus_transfer_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_transfer_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_arbiter.sv
// bus_transfer_arbiter
// Shares the internal bus between NUM_REQ requesters. A round-robin grant in
// IDLE latches the winner's source select and decoded destination load enable
// straight into the output registers. The following DRIVE cycle presents them
// to the bus mux and the register file, so each transfer takes two cycles.
//
// Ports:
//   clock       rising-edge clock
//   clear_n     asynchronous active-low reset
//   req         per-requester level request
//   req_src     packed source codes, requester i at [i*SEL_W +: SEL_W]
//   req_dst     packed destination codes, same packing
//   ack         one-cycle completion pulse per requester
//   err         one-cycle pulse alongside ack when the source code is invalid
//   bus_select  bus multiplexer select (IDLE_SEL when no transfer is active)
//   load_en     one-hot destination register load enable
//   grant_id    index of the current or last winner
//   busy        high while in DRIVE
//   xfer_count  completed non-error transfers, wrapping
module bus_transfer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = 5,
    parameter int NUM_SRC  = 24,
    parameter int IDLE_SEL = 31,
    parameter int CNT_W    = 16,
    localparam int IDW     = $clog2(NUM_REQ),
    localparam int LD_W    = 2**SEL_W
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SEL_W-1:0] req_src,
    input  logic [NUM_REQ*SEL_W-1:0] req_dst,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       err,
    output logic [SEL_W-1:0]         bus_select,
    output logic [LD_W-1:0]          load_en,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         xfer_count
);

    typedef enum logic {IDLE, DRIVE} state_t;

    localparam logic [SEL_W-1:0] IDLE_V = SEL_W'(IDLE_SEL);
    localparam logic [SEL_W:0]   NSRC_V = (SEL_W+1)'(NUM_SRC);

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [LD_W-1:0]    ld_q, ld_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               found;
    logic [IDW-1:0]     win;
    logic [SEL_W-1:0]   win_src, win_dst;

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        win_src = req_src[win*SEL_W +: SEL_W];
        win_dst = req_dst[win*SEL_W +: SEL_W];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        sel_d   = IDLE_V;
        ld_d    = '0;
        ack_d   = '0;
        err_d   = '0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = DRIVE;
                    ptr_d      = win;
                    gid_d      = win;
                    sel_d      = win_src;
                    busy_d     = 1'b1;
                    ack_d[win] = 1'b1;
                    // Destination is not range-checked; only the source is.
                    if ({1'b0, win_src} < NSRC_V) ld_d[win_dst] = 1'b1;
                    else                          err_d[win]    = 1'b1;
                end
            end
            DRIVE: begin
                state_d = IDLE;
                // err_q still holds this transfer's validity during DRIVE.
                if (err_q == '0) cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NUM_REQ-1);
            gid_q   <= '0;
            sel_q   <= IDLE_V;
            ld_q    <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            sel_q   <= sel_d;
            ld_q    <= ld_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign bus_select = sel_q;
    assign load_en    = ld_q;
    assign grant_id   = gid_q;
    assign busy       = busy_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
module tb_bus_transfer_arbiter;

    localparam int CW = 4;   // narrow counter so wrap is reachable quickly

    logic        clock = 1'b0;
    logic        clear_n;
    logic [3:0]  req;
    logic [19:0] req_src, req_dst;
    logic [3:0]  ack, err;
    logic [4:0]  bus_select;
    logic [31:0] load_en;
    logic [1:0]  grant_id;
    logic        busy;
    logic [CW-1:0] xfer_count;

    int tests = 0;
    int fails = 0;

    bus_transfer_arbiter #(.NUM_REQ(4), .SEL_W(5), .NUM_SRC(24), .IDLE_SEL(31), .CNT_W(CW)) dut (
        .clock(clock), .clear_n(clear_n), .req(req), .req_src(req_src), .req_dst(req_dst),
        .ack(ack), .err(err), .bus_select(bus_select), .load_en(load_en),
        .grant_id(grant_id), .busy(busy), .xfer_count(xfer_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rn;
        logic [3:0]  rq;
        logic [19:0] src;
        logic [19:0] dst;
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [4:0]  sel;
        logic [31:0] ld;
        logic [1:0]  gid;
        logic        busy;
        logic [CW-1:0] cnt;
    } vec_t;

    localparam logic [19:0] S1 = {15'd0, 5'd3};
    localparam logic [19:0] D1 = {15'd0, 5'd7};
    localparam logic [19:0] SA = {5'd8, 5'd6, 5'd5, 5'd4};
    localparam logic [19:0] DA = {5'd13, 5'd12, 5'd11, 5'd10};
    localparam logic [19:0] SB = {5'd8, 5'd25, 5'd5, 5'd4};
    localparam logic [19:0] DB = {5'd13, 5'd9, 5'd11, 5'd10};

    vec_t vecs[25];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string nm, input logic [CW-1:0] c);
        chk({nm, " ack"}, 64'(ack), 64'h0);
        chk({nm, " err"}, 64'(err), 64'h0);
        chk({nm, " sel"}, 64'(bus_select), 64'd31);
        chk({nm, " ld"}, 64'(load_en), 64'h0);
        chk({nm, " busy"}, 64'(busy), 64'h0);
        chk({nm, " cnt"}, 64'(xfer_count), 64'(c));
    endtask

    // One transfer by requester 1; returns to IDLE before exiting.
    task automatic xfer1(input logic [4:0] s, input logic [4:0] d, input logic [CW-1:0] cnt_after);
        logic bad;
        bad     = (s >= 5'd24);
        req     = 4'b0010;
        req_src = {10'd0, s, 5'd0};
        req_dst = {10'd0, d, 5'd0};
        step();
        chk("x ack", 64'(ack), 64'h2);
        chk("x err", 64'(err), bad ? 64'h2 : 64'h0);
        chk("x sel", 64'(bus_select), 64'(s));
        chk("x ld", 64'(load_en), bad ? 64'h0 : (64'h1 << d));
        req = 4'b0000;
        step();
        chk("x cnt", 64'(xfer_count), 64'(cnt_after));
    endtask

    initial begin
        //            rn  req     src dst ack     err     sel  ld           gid busy cnt
        vecs[0]  = '{1'b1, 4'b0001, S1, D1, 4'b0001, 4'b0000, 5'd3,  32'h80,   2'd0, 1'b1, 4'd0};
        vecs[1]  = '{1'b1, 4'b0000, S1, D1, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd0, 1'b0, 4'd1};
        vecs[2]  = '{1'b0, 4'b0000, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 4'b1111, SA, DA, 4'b0001, 4'b0000, 5'd4,  32'h400,  2'd0, 1'b1, 4'd0};
        vecs[4]  = '{1'b1, 4'b1111, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd0, 1'b0, 4'd1};
        vecs[5]  = '{1'b1, 4'b1111, SA, DA, 4'b0010, 4'b0000, 5'd5,  32'h800,  2'd1, 1'b1, 4'd1};
        vecs[6]  = '{1'b1, 4'b1111, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd1, 1'b0, 4'd2};
        vecs[7]  = '{1'b1, 4'b1111, SA, DA, 4'b0100, 4'b0000, 5'd6,  32'h1000, 2'd2, 1'b1, 4'd2};
        vecs[8]  = '{1'b1, 4'b1111, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd2, 1'b0, 4'd3};
        vecs[9]  = '{1'b1, 4'b1111, SA, DA, 4'b1000, 4'b0000, 5'd8,  32'h2000, 2'd3, 1'b1, 4'd3};
        vecs[10] = '{1'b1, 4'b1111, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd3, 1'b0, 4'd4};
        vecs[11] = '{1'b1, 4'b1111, SA, DA, 4'b0001, 4'b0000, 5'd4,  32'h400,  2'd0, 1'b1, 4'd4};
        vecs[12] = '{1'b1, 4'b0000, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd0, 1'b0, 4'd5};
        vecs[13] = '{1'b1, 4'b0100, SB, DB, 4'b0100, 4'b0100, 5'd25, 32'h0,    2'd2, 1'b1, 4'd5};
        vecs[14] = '{1'b1, 4'b0000, SB, DB, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd2, 1'b0, 4'd5};
        vecs[15] = '{1'b1, 4'b1000, SA, DA, 4'b1000, 4'b0000, 5'd8,  32'h2000, 2'd3, 1'b1, 4'd5};
        vecs[16] = '{1'b1, 4'b0000, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd3, 1'b0, 4'd6};
        vecs[17] = '{1'b1, 4'b1001, SA, DA, 4'b0001, 4'b0000, 5'd4,  32'h400,  2'd0, 1'b1, 4'd6};
        vecs[18] = '{1'b1, 4'b1000, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd0, 1'b0, 4'd7};
        vecs[19] = '{1'b1, 4'b1000, SA, DA, 4'b1000, 4'b0000, 5'd8,  32'h2000, 2'd3, 1'b1, 4'd7};
        vecs[20] = '{1'b1, 4'b0000, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd3, 1'b0, 4'd8};
        vecs[21] = '{1'b1, 4'b0001, SA, DA, 4'b0001, 4'b0000, 5'd4,  32'h400,  2'd0, 1'b1, 4'd8};
        vecs[22] = '{1'b1, 4'b0010, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd0, 1'b0, 4'd9};
        vecs[23] = '{1'b1, 4'b0000, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd0, 1'b0, 4'd9};
        vecs[24] = '{1'b1, 4'b0000, SA, DA, 4'b0000, 4'b0000, 5'd31, 32'h0,    2'd0, 1'b0, 4'd9};

        clear_n = 1'b0;
        req     = '0;
        req_src = '0;
        req_dst = '0;
        #12;
        chk_idle("reset", '0);
        chk("reset gid", 64'(grant_id), 64'h0);
        clear_n = 1'b1;
        step();

        for (int i = 0; i < 25; i++) begin
            clear_n = vecs[i].rn;
            req     = vecs[i].rq;
            req_src = vecs[i].src;
            req_dst = vecs[i].dst;
            step();
            chk($sformatf("v%0d ack", i),  64'(ack),        64'(vecs[i].ack));
            chk($sformatf("v%0d err", i),  64'(err),        64'(vecs[i].err));
            chk($sformatf("v%0d sel", i),  64'(bus_select), 64'(vecs[i].sel));
            chk($sformatf("v%0d ld", i),   64'(load_en),    64'(vecs[i].ld));
            chk($sformatf("v%0d gid", i),  64'(grant_id),   64'(vecs[i].gid));
            chk($sformatf("v%0d busy", i), 64'(busy),       64'(vecs[i].busy));
            chk($sformatf("v%0d cnt", i),  64'(xfer_count), 64'(vecs[i].cnt));
        end

        // Source code boundary and counter wrap (count is 9 here).
        xfer1(5'd23, 5'd31, 4'd10);
        xfer1(5'd24, 5'd2,  4'd10);
        xfer1(5'd0,  5'd0,  4'd11);
        xfer1(5'd1,  5'd1,  4'd12);
        xfer1(5'd2,  5'd2,  4'd13);
        xfer1(5'd3,  5'd3,  4'd14);
        xfer1(5'd4,  5'd4,  4'd15);
        xfer1(5'd5,  5'd5,  4'd0);

        // Asynchronous reset in the middle of DRIVE aborts the transfer.
        req     = 4'b0001;
        req_src = {15'd0, 5'd20};
        req_dst = {15'd0, 5'd1};
        step();
        chk("abort pre ack", 64'(ack), 64'h1);
        chk("abort pre ld", 64'(load_en), 64'h2);
        #2;
        clear_n = 1'b0;
        #1;
        chk_idle("abort", '0);
        chk("abort gid", 64'(grant_id), 64'h0);
        req = 4'b0000;
        #2;
        clear_n = 1'b1;
        step();
        chk_idle("after abort 1", '0);
        step();
        chk_idle("after abort 2", '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
